// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/gnt/rvalid memory requests and buffers
// returned words in an in-order queue presented to decode with valid/ready.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   PCSrc_i,
  input  logic [ADDR_WIDTH-1:0]  PCTarget_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pcplus4_o
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1) + 1;
  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [INSTR_WIDTH-1:0] NOP   = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0]  STEP  = ADDR_WIDTH'(4);
  localparam logic [CW-1:0]          DEPTH = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0]          LAST  = PW'(QUEUE_DEPTH - 1);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_next;

  logic [INSTR_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [QUEUE_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count, count_next;
  logic [CW-1:0]          outstanding, outstanding_next;
  logic [CW-1:0]          discard, discard_next, live;
  logic [ADDR_WIDTH-1:0]  fetch_pc, resp_pc, target_pc;
  logic                   running, redirect, fire, resp, drop, push, pop, empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= BOOT;
    else          state <= state_next;
  end

  // Credit rule: queued words plus live requests never exceed the queue depth,
  // so a response can always be pushed without a full check.
  always_comb begin
    state_next       = state;
    running          = (state == RUN);
    live             = outstanding - discard;
    empty            = (count == '0);
    target_pc        = PCTarget_i & ~ADDR_WIDTH'(3);
    redirect         = running && PCSrc_i;
    imem_req_o       = running && ((count + live) < DEPTH);
    fire             = imem_req_o && imem_gnt_i;
    resp             = running && imem_rvalid_i && (outstanding != '0);
    drop             = resp && (discard != '0);
    push             = resp && !drop && !redirect;
    pop              = !empty && instr_ready_i && !redirect;
    outstanding_next = outstanding + CW'(fire) - CW'(resp);
    discard_next     = discard;
    count_next       = count + CW'(push) - CW'(pop);
    if (state == BOOT) state_next = RUN;
    if (redirect) begin
      discard_next = outstanding_next;
      count_next   = '0;
    end else if (drop) begin
      discard_next = discard - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      count       <= count_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (fire) fetch_pc <= fetch_pc + STEP;
        if (push) begin
          resp_pc <= resp_pc + STEP;
          wr_ptr  <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? NOP : instr_mem[rd_ptr];
  assign pc_o          = empty ? '0 : pc_mem[rd_ptr];
  assign pcplus4_o     = empty ? '0 : pc_mem[rd_ptr] + STEP;

  // A response with nothing outstanding is a bus protocol violation.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && state == RUN && imem_rvalid_i) assert (outstanding != '0);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with fixed latency plus a
// scoreboard of expected decode entries, a boot vector table and corner sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pcsrc = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0] target = '0, rdata = '0;
  logic        req, valid;
  logic [31:0] addr, instr, pc, pcplus4;

  instr_fetch_unit #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RPC), .QUEUE_DEPTH(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .PCSrc_i(pcsrc), .PCTarget_i(target),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_ready_i(ready),
    .instr_o(instr), .pc_o(pc), .pcplus4_o(pcplus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_fetch = RPC;
  int          cyc = 0, lat = 1;
  int          checks = 0, errors = 0;
  vec_t        boot_tbl[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC3, a[23:0]} ^ 32'h0055_AA00;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle at the negedge: memory responds, decode consumes, grants enqueue
  // expectations and a redirect flushes everything the bench still expected.
  task automatic apply_stimulus();
    exp_t e;
    rvalid = 1'b0;
    rdata  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (valid && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_instr: got pc %h, expected no valid entry", pc);
      end else begin
        e = sb.pop_front();
        check_output("sb_instr", instr, e.instr);
        check_output("sb_pc", pc, e.pc);
        check_output("sb_pcplus4", pcplus4, e.pc + 32'd4);
      end
    end
    if (req && gnt) begin
      check_output("fetch_addr", addr, exp_fetch);
      pend_addr.push_back(addr);
      pend_due.push_back(cyc + lat);
      sb.push_back('{instr: mem_word(exp_fetch), pc: exp_fetch});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (pcsrc) begin
      sb.delete();
      exp_fetch = {target[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic drain();
    gnt   = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || pend_addr.size() != 0); i++) apply_stimulus();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req"}, req, 1'b0);
    check_output({tag, "_addr"}, addr, RPC);
    check_output({tag, "_valid"}, valid, 1'b0);
    check_output({tag, "_instr"}, instr, NOP);
    check_output({tag, "_pc"}, pc, '0);
    check_output({tag, "_pcplus4"}, pcplus4, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    boot_tbl[0] = '{req: 1'b0, addr: 32'h0, valid: 1'b0, pc: 32'h0};
    boot_tbl[1] = '{req: 1'b1, addr: 32'h0, valid: 1'b0, pc: 32'h0};
    boot_tbl[2] = '{req: 1'b1, addr: 32'h4, valid: 1'b0, pc: 32'h0};
    boot_tbl[3] = '{req: 1'b0, addr: 32'h8, valid: 1'b1, pc: 32'h0};
    boot_tbl[4] = '{req: 1'b1, addr: 32'h8, valid: 1'b1, pc: 32'h4};
    boot_tbl[5] = '{req: 1'b1, addr: 32'hC, valid: 1'b0, pc: 32'h0};
    boot_tbl[6] = '{req: 1'b0, addr: 32'h10, valid: 1'b1, pc: 32'h8};

    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot: gnt always high, one-cycle response latency, decode always ready
    gnt   = 1'b1;
    ready = 1'b1;
    lat   = 1;
    for (int i = 0; i < 7; i++) begin
      check_output("boot_req", req, boot_tbl[i].req);
      check_output("boot_addr", addr, boot_tbl[i].addr);
      check_output("boot_valid", valid, boot_tbl[i].valid);
      check_output("boot_pc", pc, boot_tbl[i].pc);
      check_output("boot_instr", instr, boot_tbl[i].valid ? mem_word(boot_tbl[i].pc) : NOP);
      check_output("boot_pcplus4", pcplus4, boot_tbl[i].valid ? boot_tbl[i].pc + 32'd4 : 32'h0);
      apply_stimulus();
    end

    // Backpressure: queue fills to exactly two entries and requests stop
    ready = 1'b0;
    run_cycles(10);
    check_output("bp_valid", valid, 1'b1);
    check_output("bp_req", req, 1'b0);
    gnt   = 1'b0;
    ready = 1'b1;
    apply_stimulus();
    check_output("bp_second_valid", valid, 1'b1);
    apply_stimulus();
    check_output("bp_empty_after_two", valid, 1'b0);
    gnt = 1'b1;
    run_cycles(12);
    drain();

    // Redirect with two requests in flight
    lat = 4;
    gnt = 1'b1;
    run_cycles(2);
    check_output("rd2_req_blocked", req, 1'b0);
    gnt    = 1'b0;
    pcsrc  = 1'b1;
    target = 32'h0000_0103;
    apply_stimulus();
    pcsrc = 1'b0;
    check_output("rd2_req", req, 1'b1);
    check_output("rd2_addr", addr, 32'h0000_0100);
    check_output("rd2_valid", valid, 1'b0);
    gnt = 1'b1;
    run_cycles(14);
    drain();

    // Redirect, grant and response all in the same cycle
    lat = 1;
    gnt = 1'b1;
    apply_stimulus();
    check_output("same_req", req, 1'b1);
    pcsrc  = 1'b1;
    target = 32'h0000_0200;
    apply_stimulus();
    pcsrc = 1'b0;
    check_output("same_valid_next", valid, 1'b0);
    check_output("same_req_next", req, 1'b1);
    check_output("same_addr_next", addr, 32'h0000_0200);
    apply_stimulus();
    check_output("same_stale_dropped", valid, 1'b0);
    run_cycles(10);
    drain();

    // Wait states: address held while gnt is low, then slow responses
    lat = 4;
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output("ws_req", req, 1'b1);
      check_output("ws_addr", addr, exp_fetch);
      apply_stimulus();
    end
    gnt = 1'b1;
    run_cycles(16);
    drain();

    // Address wrap at the top of the space
    lat    = 2;
    pcsrc  = 1'b1;
    target = 32'hFFFF_FFFE;
    apply_stimulus();
    pcsrc = 1'b0;
    check_output("wrap_addr", addr, 32'hFFFF_FFFC);
    gnt = 1'b1;
    run_cycles(8);
    drain();

    // Asynchronous reset in the middle of a stream
    gnt = 1'b1;
    run_cycles(6);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    sb.delete();
    pend_addr.delete();
    pend_due.delete();
    exp_fetch = RPC;
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    check_output("post_reset_boot_req", req, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rvalid = 1'b0;
    check_output("post_reset_valid", valid, 1'b0);
    check_output("post_reset_req", req, 1'b1);
    check_output("post_reset_addr", addr, RPC);
    gnt = 1'b1;
    run_cycles(10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
